// File: rtl/pot_mac_seq_if.sv
// Purpose: job control, pair input stream and result stream of pot_mac_seq.
// Latency: none; signal bundle only.
// Backpressure: in_ready throttles the pair stream, out_ready holds the result.
interface pot_mac_seq_if #(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int MAX_LEN          = 16
);
    localparam int PROD_W = INPUT_BIT_WIDTH + 2**WEIGHT_BIT_WIDTH;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ACC_W  = PROD_W + LEN_W;

    logic                              start;
    logic [LEN_W-1:0]                  len;
    logic                              busy;
    logic                              in_valid;
    logic                              in_ready;
    logic signed [INPUT_BIT_WIDTH-1:0] in_data;
    logic [WEIGHT_BIT_WIDTH-1:0]       in_weight;
    logic                              out_valid;
    logic                              out_ready;
    logic signed [ACC_W-1:0]           out_acc;
    logic [LEN_W-1:0]                  out_count;

    modport master (
        output start, len, in_valid, in_data, in_weight, out_ready,
        input  busy, in_ready, out_valid, out_acc, out_count
    );

    modport slave (
        input  start, len, in_valid, in_data, in_weight, out_ready,
        output busy, in_ready, out_valid, out_acc, out_count
    );
endinterface

// File: rtl/pot_mac_seq.sv
// Purpose: sequential power-of-two MAC; one shift term per accepted pair, summed per job.
// Latency: last pair transfer in cycle T -> out_valid in cycle T+2; 1 pair/cycle sustained.
// Backpressure: in_ready only in RUN with pairs left; result held in DONE until out_ready.
module pot_mac_seq #(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int MAX_LEN          = 16
) (
    input logic          clk,
    input logic          rst,
    pot_mac_seq_if.slave bus
);
    localparam int ZERO_W = 2**WEIGHT_BIT_WIDTH;
    localparam int PROD_W = INPUT_BIT_WIDTH + ZERO_W;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ACC_W  = PROD_W + LEN_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    in_ready;
    logic                    out_valid;
    logic                    busy;
    logic                    xfer;
    logic [LEN_W-1:0]        len_c;
    logic [LEN_W-1:0]        remaining;
    logic [LEN_W-1:0]        count;
    logic signed [ACC_W-1:0] acc;
    logic [PROD_W-1:0]       p_reg;
    logic                    p_vld;
    logic [PROD_W-1:0]       ext;
    logic [PROD_W-1:0]       shifted;
    logic [PROD_W-1:0]       term;

    // Oversized job lengths saturate at the largest supported job.
    assign len_c = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
    assign xfer  = bus.in_valid & in_ready;

    // Shift datapath: input placed at the top of the product word, then scaled down.
    assign ext     = {bus.in_data, {ZERO_W{1'b0}}};
    assign shifted = ext >> bus.in_weight[WEIGHT_BIT_WIDTH-2:0];
    assign term    = bus.in_weight[WEIGHT_BIT_WIDTH-1] ? (PROD_W'(0) - shifted) : shifted;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_nxt = (len_c == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = (remaining != '0);
                if (xfer && remaining == LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Product stage and accumulator: each term lands in acc the cycle after its transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            count     <= '0;
            acc       <= '0;
            p_reg     <= '0;
            p_vld     <= 1'b0;
        end else begin
            p_vld <= xfer;
            if (xfer) p_reg <= term;
            if (state == IDLE && bus.start) begin
                remaining <= len_c;
                count     <= '0;
                acc       <= '0;
            end else begin
                if (p_vld) acc <= acc + {{LEN_W{p_reg[PROD_W-1]}}, p_reg};
                if (xfer) begin
                    remaining <= remaining - LEN_W'(1);
                    count     <= count + LEN_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_acc   = acc;
    assign bus.out_count = count;
endmodule

// File: tb/tb_pot_mac_seq.sv
// Purpose: directed checks of pot_mac_seq jobs, stalls, result hold, reset and length limits.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises in_valid gaps and out_ready held low in DONE.
module tb_pot_mac_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rdy_cnt = 0;
    int   xfer_cnt = 0;

    pot_mac_seq_if bus ();

    pot_mac_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge-sampled activity counters used for handshake checks.
    always @(posedge clk) begin
        if (bus.in_ready) rdy_cnt <= rdy_cnt + 1;
        if (bus.in_valid && bus.in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        bus.len   = 5'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) chk("done_timeout", 0, 1);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    int d3[3] = '{3, 3, 3};
    int w3[3] = '{0, 1, 9};
    int v4[4] = '{1, 0, 0, 1};
    int d4[4] = '{-2, 7, 5, 1};
    int w4[4] = '{0, 9, 3, 2};

    initial begin
        int lat;
        int r0;
        int x0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_acc", bus.out_acc, 0);
        chk("rst_count", bus.out_count, 0);
        rst = 1'b0;
        tick();

        // Reset while the result is pending.
        start_job(1);
        bus.in_valid = 1'b1; bus.in_data = 4'sd3; bus.in_weight = 4'd0;
        tick();
        bus.in_valid = 1'b0;
        wait_done(lat);
        chk("pre_rst_acc", bus.out_acc, 196608);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_acc", bus.out_acc, 0);
        chk("mid_rst_count", bus.out_count, 0);

        // Three back-to-back pairs.
        r0 = rdy_cnt;
        start_job(3);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data   = 4'(d3[i]);
            bus.in_weight = 4'(w3[i]);
            chk("b2b_in_ready", bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("b2b_drain_no_valid", bus.out_valid, 0);
        tick();
        chk("b2b_valid_t2", bus.out_valid, 1);
        chk("b2b_acc", bus.out_acc, 196608);
        chk("b2b_count", bus.out_count, 3);
        chk("b2b_ready_cycles", rdy_cnt - r0, 3);
        accept();
        chk("b2b_idle", bus.busy, 0);

        // Two pairs with stall cycles carrying junk data.
        x0 = xfer_cnt;
        start_job(2);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = v4[i][0];
            bus.in_data   = 4'(d4[i]);
            bus.in_weight = 4'(w4[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stall_xfers", xfer_cnt - x0, 2);
        wait_done(lat);
        chk("stall_acc", bus.out_acc, -114688);
        chk("stall_count", bus.out_count, 2);
        accept();

        // Empty job.
        r0 = rdy_cnt;
        start_job(0);
        wait_done(lat);
        chk("len0_lat_ok", (lat + 1 <= 2), 1);
        chk("len0_acc", bus.out_acc, 0);
        chk("len0_count", bus.out_count, 0);
        chk("len0_no_ready", rdy_cnt - r0, 0);
        accept();

        // Result held under backpressure; start ignored while busy.
        start_job(1);
        bus.in_valid = 1'b1; bus.in_data = 4'sd3; bus.in_weight = 4'd1;
        tick();
        bus.in_valid = 1'b0;
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            bus.len   = 5'd3;
            tick();
            chk("hold_acc", bus.out_acc, 98304);
            chk("hold_valid", bus.out_valid, 1);
        end
        chk("hold_count", bus.out_count, 1);
        bus.start = 1'b1;
        accept();
        bus.start = 1'b0;
        chk("hold_release_busy", bus.busy, 0);
        chk("hold_release_valid", bus.out_valid, 0);
        tick();
        chk("start_with_ready_ignored", bus.busy, 0);

        // Full-length job of most negative terms.
        r0 = rdy_cnt;
        start_job(16);
        bus.in_valid = 1'b1; bus.in_data = -4'sd8; bus.in_weight = 4'd0;
        wait_done(lat);
        bus.in_valid = 1'b0;
        chk("max_acc", bus.out_acc, -8388608);
        chk("max_count", bus.out_count, 16);
        chk("max_ready_cycles", rdy_cnt - r0, 16);
        accept();

        // Oversized length saturates.
        r0 = rdy_cnt;
        start_job(31);
        bus.in_valid = 1'b1; bus.in_data = 4'sd1; bus.in_weight = 4'd0;
        wait_done(lat);
        bus.in_valid = 1'b0;
        chk("clamp_acc", bus.out_acc, 1048576);
        chk("clamp_count", bus.out_count, 16);
        chk("clamp_ready_cycles", rdy_cnt - r0, 16);
        accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
